// File: rtl/alu_exec_sequencer_if.sv
// Instruction handshake bundle between the issuing stage and the ALU sequencer.
interface alu_exec_sequencer_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] instr_op;
  logic [7:0] instr_imm;

  // Issuer drives the instruction, the sequencer answers with ready.
  modport master (output instr_valid, output instr_op, output instr_imm, input instr_ready);
  modport slave  (input instr_valid, input instr_op, input instr_imm, output instr_ready);
endinterface

// File: rtl/alu_exec_sequencer.sv
// Sequencer in front of a combinational 8-bit ALU: owns the accumulator, the
// data register and the status flags, drives the ALU controls for a settle
// window and writes the ALU result back into the accumulator.
module alu_exec_sequencer #(
  parameter int unsigned SETTLE_CYCLES        = 1,
  parameter int unsigned MULDIV_SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_exec_sequencer_if.slave  instr_if,
  output logic [7:0]           alu_a_o,
  output logic [7:0]           alu_b_o,
  output logic [2:0]           alu_op_select_o,
  output logic                 alu_sub_o,
  input  logic [7:0]           alu_result_i,
  input  logic                 alu_cout_i,
  input  logic                 alu_overflow_i,
  input  logic                 alu_no_i,
  input  logic                 alu_zo_i,
  output logic [7:0]           acc_o,
  output logic                 flag_c_o,
  output logic                 flag_v_o,
  output logic                 flag_n_o,
  output logic                 flag_z_o,
  output logic                 div_zero_o,
  output logic                 illegal_op_o,
  output logic                 done_o,
  output logic                 busy_o
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDA  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_DIV  = 4'd7;
  localparam logic [3:0] OP_CLRF = 4'd8;

  localparam int unsigned MAX_SETTLE =
    (SETTLE_CYCLES > MULDIV_SETTLE_CYCLES) ? SETTLE_CYCLES : MULDIV_SETTLE_CYCLES;
  localparam int CNT_W = (MAX_SETTLE < 2) ? 1 : $clog2(MAX_SETTLE + 1);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         acc_q, acc_d;
  logic [7:0]         dreg_q, dreg_d;
  logic [2:0]         sel_q, sel_d;
  logic               sub_q, sub_d;
  logic               c_q, c_d, v_q, v_d, n_q, n_d, z_q, z_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;
  logic               ill_q, ill_d;

  // Architectural state register; reset mid-EXEC drops the operation unwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      dreg_q  <= '0;
      sel_q   <= '0;
      sub_q   <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dreg_q  <= dreg_d;
      sel_q   <= sel_d;
      sub_q   <= sub_d;
      c_q     <= c_d;
      v_q     <= v_d;
      n_q     <= n_d;
      z_q     <= z_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
    end
  end

  // Instruction decode, settle counting and writeback next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dreg_d  = dreg_q;
    sel_d   = sel_q;
    sub_d   = sub_q;
    c_d     = c_q;
    v_d     = v_q;
    n_d     = n_q;
    z_d     = z_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    ill_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (instr_if.instr_valid) begin
          case (instr_if.instr_op)
            OP_NOP: done_d = 1'b1;
            OP_LDA: begin
              acc_d  = instr_if.instr_imm;
              n_d    = instr_if.instr_imm[7];
              z_d    = (instr_if.instr_imm == 8'd0);
              done_d = 1'b1;
            end
            OP_CLRF: begin
              c_d    = 1'b0;
              v_d    = 1'b0;
              n_d    = 1'b0;
              z_d    = 1'b0;
              dz_d   = 1'b0;
              done_d = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV: begin
              if (instr_if.instr_op == OP_DIV && instr_if.instr_imm == 8'd0) begin
                // Divide by zero retires at once without touching the ALU.
                dz_d   = 1'b1;
                done_d = 1'b1;
              end else begin
                dreg_d  = instr_if.instr_imm;
                sel_d   = 3'(instr_if.instr_op - OP_ADD);
                sub_d   = (instr_if.instr_op == OP_SUB);
                cnt_d   = (instr_if.instr_op == OP_MUL || instr_if.instr_op == OP_DIV)
                          ? CNT_W'(MULDIV_SETTLE_CYCLES) : CNT_W'(SETTLE_CYCLES);
                state_d = EXEC;
              end
            end
            default: ill_d = 1'b1;
          endcase
        end
      end
      EXEC: begin
        // A count of zero is treated as one so the window always terminates.
        if (cnt_q <= CNT_W'(1)) begin
          acc_d = alu_result_i;
          if (sel_q <= 3'd1) begin
            c_d = alu_cout_i;
            v_d = alu_overflow_i;
            n_d = alu_no_i;
            z_d = alu_zo_i;
          end else begin
            // Logic and mul/div flags come from the result, not the ALU N/Z.
            c_d = 1'b0;
            v_d = 1'b0;
            n_d = alu_result_i[7];
            z_d = (alu_result_i == 8'd0);
          end
          sel_d   = 3'd0;
          sub_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign instr_if.instr_ready = (state_q == IDLE);
  assign busy_o          = (state_q == EXEC);
  assign alu_a_o         = acc_q;
  assign alu_b_o         = dreg_q;
  assign alu_op_select_o = sel_q;
  assign alu_sub_o       = sub_q;
  assign acc_o           = acc_q;
  assign flag_c_o        = c_q;
  assign flag_v_o        = v_q;
  assign flag_n_o        = n_q;
  assign flag_z_o        = z_q;
  assign div_zero_o      = dz_q;
  assign illegal_op_o    = ill_q;
  assign done_o          = done_q;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Bench for alu_exec_sequencer: a combinational ALU model closes the loop and
// an instruction-level reference model predicts acc, flags and timing.
module tb_alu_exec_sequencer;

  localparam int SETTLE = 1;
  localparam int MULDIV = 2;

  localparam logic [3:0] NOP = 4'd0, LDA = 4'd1, ADD = 4'd2, SUB = 4'd3, AND_ = 4'd4,
                         OR_ = 4'd5, MUL = 4'd6, DIV = 4'd7, CLRF = 4'd8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_exec_sequencer_if ifc ();

  logic [7:0] alu_a, alu_b, alu_result, acc;
  logic [2:0] alu_sel;
  logic       alu_sub, alu_cout, alu_ovf, alu_no, alu_zo;
  logic       fc, fv, fn, fz, dz, ill, done, busy;

  alu_exec_sequencer #(.SETTLE_CYCLES(SETTLE), .MULDIV_SETTLE_CYCLES(MULDIV)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .instr_if        (ifc),
    .alu_a_o         (alu_a),
    .alu_b_o         (alu_b),
    .alu_op_select_o (alu_sel),
    .alu_sub_o       (alu_sub),
    .alu_result_i    (alu_result),
    .alu_cout_i      (alu_cout),
    .alu_overflow_i  (alu_ovf),
    .alu_no_i        (alu_no),
    .alu_zo_i        (alu_zo),
    .acc_o           (acc),
    .flag_c_o        (fc),
    .flag_v_o        (fv),
    .flag_n_o        (fn),
    .flag_z_o        (fz),
    .div_zero_o      (dz),
    .illegal_op_o    (ill),
    .done_o          (done),
    .busy_o          (busy)
  );

  // Combinational ALU. For non add/sub selects the carry/overflow/N/Z outputs
  // are deliberately bogus so the sequencer must derive those flags itself.
  logic [7:0] bb;
  logic [8:0] s9;
  always_comb begin
    alu_result = 8'd0;
    alu_cout   = 1'b0;
    alu_ovf    = 1'b0;
    alu_no     = 1'b0;
    alu_zo     = 1'b0;
    bb         = alu_sub ? ~alu_b : alu_b;
    s9         = {1'b0, alu_a} + {1'b0, bb} + {8'd0, alu_sub};
    case (alu_sel)
      3'd0, 3'd1: begin
        alu_result = s9[7:0];
        alu_cout   = s9[8];
        alu_ovf    = (alu_a[7] == bb[7]) && (s9[7] != alu_a[7]);
        alu_no     = s9[7];
        alu_zo     = (s9[7:0] == 8'd0);
      end
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = 8'((16'(alu_a) * 16'(alu_b)));
      3'd5: alu_result = (alu_b != 8'd0) ? (alu_a / alu_b) : 8'hFF;
      default: alu_result = 8'd0;
    endcase
    if (alu_sel >= 3'd2) begin
      alu_cout = 1'b1;
      alu_ovf  = 1'b1;
      alu_no   = ~alu_result[7];
      alu_zo   = (alu_result != 8'd0);
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference architectural state.
  logic [7:0] m_acc;
  logic       m_c, m_v, m_n, m_z, m_dz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sval(input int u);
    return (u >= 128) ? u - 256 : u;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_acc"}, acc, m_acc);
    check({tag, "_cvnz"}, {fc, fv, fn, fz}, {m_c, m_v, m_n, m_z});
    check({tag, "_dz"}, dz, m_dz);
  endtask

  // Issue one instruction from a negedge, follow it to retirement, check result.
  task automatic run_instr(input logic [3:0] op, input logic [7:0] imm,
                           input bit hold, input bit expect_no_wait);
    int waits = 0;
    int lat = 0;
    int a, b, res, sr;
    bit is_ill = 0, ex = 0;
    logic [2:0] esel = 3'd0;
    logic esub = 1'b0;
    logic [7:0] a_before;

    ifc.instr_valid = 1'b1;
    ifc.instr_op    = op;
    ifc.instr_imm   = imm;
    while (!ifc.instr_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (expect_no_wait) check("no_gap_wait", waits, 0);
    if (!ifc.instr_ready) begin
      check("ready_timeout", ifc.instr_ready, 1'b1);
      ifc.instr_valid = 1'b0;
      return;
    end

    a_before = m_acc;
    a = int'(m_acc);
    b = int'(imm);
    res = 0;
    case (op)
      NOP: ;
      LDA: begin m_acc = imm; m_n = imm[7]; m_z = (imm == 8'd0); end
      CLRF: begin m_c = 0; m_v = 0; m_n = 0; m_z = 0; m_dz = 0; end
      ADD: begin
        ex = 1; lat = SETTLE; esel = 3'd0;
        res = (a + b) % 256; m_c = (a + b) > 255;
        sr = sval(a) + sval(b); m_v = (sr > 127) || (sr < -128);
      end
      SUB: begin
        ex = 1; lat = SETTLE; esel = 3'd1; esub = 1'b1;
        res = (a - b + 256) % 256; m_c = (a >= b);
        sr = sval(a) - sval(b); m_v = (sr > 127) || (sr < -128);
      end
      AND_: begin ex = 1; lat = SETTLE; esel = 3'd2; res = a & b; end
      OR_:  begin ex = 1; lat = SETTLE; esel = 3'd3; res = a | b; end
      MUL:  begin ex = 1; lat = MULDIV; esel = 3'd4; res = (a * b) % 256; end
      DIV: begin
        if (b == 0) m_dz = 1;
        else begin ex = 1; lat = MULDIV; esel = 3'd5; res = a / b; end
      end
      default: is_ill = 1;
    endcase
    if (ex) begin
      m_acc = 8'(res);
      m_n = (res >= 128);
      m_z = (res == 0);
      if (op != ADD && op != SUB) begin m_c = 0; m_v = 0; end
    end

    @(posedge clk);
    #1;
    if (!hold || is_ill) ifc.instr_valid = 1'b0;

    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k <= lat) begin
        check("exec_busy", busy, 1'b1);
        check("exec_done", done, 1'b0);
        check("exec_sel", alu_sel, esel);
        check("exec_sub", alu_sub, esub);
        check("exec_alu_a", alu_a, a_before);
        check("exec_alu_b", alu_b, imm);
      end else if (is_ill) begin
        check("ill_pulse", ill, 1'b1);
        check("ill_no_done", done, 1'b0);
      end else begin
        check("retire_done", done, 1'b1);
        check("retire_busy", busy, 1'b0);
        check("retire_ready", ifc.instr_ready, 1'b1);
        check("retire_ill", ill, 1'b0);
        if (ex) check("retire_ctrl", {alu_sel, alu_sub}, 4'd0);
      end
    end
    check_state($sformatf("op%0d", op));
    $display("instr op=%0d imm=0x%02h -> acc=0x%02h cvnz=%b dz=%b", op, imm, acc,
             {fc, fv, fn, fz}, dz);
    if (is_ill) begin
      @(negedge clk);
      check("ill_single", ill, 1'b0);
      check("ill_no_done2", done, 1'b0);
    end
  endtask

  initial begin
    logic [3:0] rop;
    logic [7:0] rimm;
    bit rhold;

    rst_n = 1'b0;
    ifc.instr_valid = 1'b0;
    ifc.instr_op    = 4'd0;
    ifc.instr_imm   = 8'd0;
    m_acc = 0; m_c = 0; m_v = 0; m_n = 0; m_z = 0; m_dz = 0;

    repeat (3) @(negedge clk);
    check("rst_acc", acc, 8'd0);
    check("rst_flags", {fc, fv, fn, fz, dz}, 5'd0);
    check("rst_pulses", {done, ill, busy}, 3'd0);
    check("rst_ready", ifc.instr_ready, 1'b1);
    check("rst_ctrl", {alu_sel, alu_sub}, 4'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed plan.
    run_instr(LDA, 8'h7F, 0, 0);
    run_instr(ADD, 8'h01, 0, 0);
    check("add_ovf_acc", acc, 8'h80);
    check("add_ovf_cvnz", {fc, fv, fn, fz}, 4'b0110);
    run_instr(LDA, 8'h05, 0, 0);
    run_instr(SUB, 8'h05, 0, 0);
    check("sub_eq_cvnz", {acc, fc, fv, fn, fz}, {8'h00, 4'b1001});
    run_instr(SUB, 8'h01, 0, 0);
    check("sub_borrow", {acc, fc, fn}, {8'hFF, 2'b01});
    run_instr(LDA, 8'h10, 0, 0);
    run_instr(MUL, 8'h10, 0, 0);
    check("mul_wrap", {acc, fc, fv, fz}, {8'h00, 3'b001});
    run_instr(LDA, 8'h64, 0, 0);
    run_instr(DIV, 8'h07, 0, 0);
    check("div_q", {acc, fz}, {8'h0E, 1'b0});
    run_instr(LDA, 8'h33, 0, 0);
    run_instr(DIV, 8'h00, 0, 0);
    check("div0_acc", {acc, dz}, {8'h33, 1'b1});
    run_instr(ADD, 8'h01, 0, 0);
    check("div0_sticky", dz, 1'b1);
    run_instr(CLRF, 8'h00, 0, 0);
    check("clrf_dz", dz, 1'b0);
    run_instr(4'hF, 8'hAA, 0, 0);
    run_instr(ADD, 8'h03, 1, 0);
    run_instr(AND_, 8'h0F, 1, 1);
    run_instr(OR_, 8'hF0, 0, 1);

    // Reset in the middle of a MUL: nothing is written and nothing retires.
    run_instr(LDA, 8'h80, 0, 0);
    ifc.instr_valid = 1'b1;
    ifc.instr_op    = MUL;
    ifc.instr_imm   = 8'h03;
    @(posedge clk);
    #1 ifc.instr_valid = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    m_acc = 0; m_c = 0; m_v = 0; m_n = 0; m_z = 0; m_dz = 0;
    check_state("abort_rst");
    check("abort_ready", {ifc.instr_ready, busy}, 2'b10);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
    end
    check_state("abort_after");
    $display("reset abort: acc=0x%02h ready=%b", acc, ifc.instr_ready);

    // Randomized instruction stream against the reference model.
    for (int i = 0; i < 80; i++) begin
      rop = 4'($urandom_range(0, 10));
      if (rop == 4'd10) rop = 4'($urandom_range(9, 15));
      rimm = 8'($urandom);
      if (rop == DIV && $urandom_range(0, 3) == 0) rimm = 8'd0;
      if ($urandom_range(0, 7) == 0) rimm = 8'hFF;
      rhold = ($urandom_range(0, 1) == 1) && (i != 79);
      run_instr(rop, rimm, rhold, 0);
    end
    ifc.instr_valid = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_sequencer.md
Name: alu_exec_sequencer

Overview:
Sequencing stage directly upstream of the 8-bit ALU.
- Accepts one instruction per valid/ready handshake and owns the accumulator (ALU operand a) and data register (ALU operand b).
- Drives the ALU operation select and subtract lines, holds them stable for a settle window, then writes the ALU result back into the accumulator and latches the status flags.
- The ALU is purely combinational; all architectural state lives here.

Parameters:
SETTLE_CYCLES, 1, EXEC cycles for ADD/SUB/AND/OR (min 1).
MULDIV_SETTLE_CYCLES, 2, EXEC cycles for MUL/DIV (min 1).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction present
instr_ready  out  1  sequencer can accept; equals (state==IDLE)
instr_op  in  4  opcode: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 MUL, 7 DIV, 8 CLRF, 9-15 illegal
instr_imm  in  8  immediate operand
alu_a  out  8  ALU operand a; always equals acc
alu_b  out  8  ALU operand b; data register
alu_op_select  out  3  ALU operation select
alu_sub  out  1  ALU subtract control
alu_result  in  8  ALU result
alu_cout  in  1  ALU carry out
alu_overflow  in  1  ALU overflow
alu_no  in  1  ALU negative flag
alu_zo  in  1  ALU zero flag
acc  out  8  accumulator
flag_c, flag_v, flag_n, flag_z  out  1 each  status flags
div_zero  out  1  sticky divide-by-zero flag
illegal_op  out  1  one-cycle pulse on an illegal opcode
done  out  1  one-cycle pulse when an instruction retires
busy  out  1  equals (state==EXEC)

Behaviour:
Reset (asynchronous, while rst_n=0):
- state=IDLE; acc, dreg, all flags, div_zero, done and illegal_op = 0.
- alu_op_select=0, alu_sub=0.
- No handshake is taken while rst_n=0. Asserting reset mid-EXEC aborts the operation; acc is not written.

States: IDLE, EXEC.

Accept rule: a handshake occurs on a rising edge with state==IDLE and instr_valid=1. At that edge:
- NOP: no state change; done=1 next cycle.
- LDA: acc<=imm, N<=imm[7], Z<=(imm==0), C and V unchanged; done=1 next cycle; stay IDLE.
- CLRF: C, V, N, Z and div_zero <= 0; done=1 next cycle; stay IDLE.
- DIV with imm==0: div_zero<=1; acc and flags unchanged; done=1 next cycle; stay IDLE.
- Illegal opcode: illegal_op=1 next cycle; no done; no state change.
- ADD/SUB/AND/OR/MUL/DIV (other cases): dreg<=imm; alu_op_select <= 0/1/2/3/4/5 respectively; alu_sub <= (op==SUB); counter <= settle count; state <= EXEC.

EXEC:
- ALU inputs stay stable and the counter decrements each cycle.
- On the edge ending the last EXEC cycle:
  - acc <= alu_result.
  - Flags written.
  - alu_op_select <= 0, alu_sub <= 0.
  - state <= IDLE; done=1 for the following cycle.
- Latency: accept edge E0, writeback at edge E0+N (N = applicable settle count); done is high in cycle E0+N..E0+N+1.
- instr_ready is high in that same cycle, so back-to-back issue with instr_valid held high loses no cycles.

Flag rules at writeback:
- ADD/SUB: C=alu_cout, V=alu_overflow, N=alu_no, Z=alu_zo.
- SUB carry means "no borrow": a>=b unsigned gives C=1.
- AND/OR/MUL/DIV: C=0, V=0, N=alu_result[7], Z=(alu_result==0). The ALU N/Z outputs are ignored for these ops.
- MUL keeps the low 8 bits only. DIV keeps the unsigned quotient.

Wrap-around: 8-bit modular arithmetic; no saturation.

Outputs acc, flags, alu_* and done are registered; instr_ready and busy are decoded from the state register.

Test Plan:
- Reset, then LDA 0x7F, then ADD 0x01 (SETTLE=1) -> ADD done exactly 1 cycle after its accept edge; acc=0x80, V=1, N=1, C=0, Z=0; alu_op_select=0 during EXEC.
- LDA 0x05, then SUB 0x05 -> acc=0x00, Z=1, C=1, V=0, alu_sub=1 only during EXEC. Then SUB 0x01 from 0x00 -> acc=0xFF, C=0, N=1.
- LDA 0x10, then MUL 0x10 (MULDIV=2) -> busy for 2 cycles; acc=0x00, Z=1, C=0, V=0. Then LDA 0x64, DIV 0x07 -> acc=0x0E, Z=0.
- LDA 0x33, then DIV 0x00 -> acc stays 0x33; div_zero=1 and stays 1 across a following ADD; CLRF clears it.
- Opcode 0xF -> illegal_op single pulse; no done; acc and flags unchanged. instr_valid held for ADD,AND,OR back-to-back -> three done pulses with no idle gaps.
- Assert rst_n=0 during EXEC of MUL -> acc and flags clear immediately; after release, instr_ready=1 and no done pulse for the aborted MUL.
